// File: rtl/shiftreg_deser.sv
// shiftreg_deser: serial-to-parallel receiver for the universal shift register link.
// Collects sin bits (qualified by sin_vld, framed by sync) into WIDTH-bit words and
// queues completed words in a 2-entry FIFO read through pout/pout_vld/pout_rdy.
// Optional build macro SHIFTREG_DESER_PARITY_EN: each word is followed by an even
// parity bit; words failing parity are dropped and perr is set (sticky).
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   en            receiver enable; low returns to IDLE and drops the partial word
//   sin, sin_vld  serial bit and its strobe
//   sync          marks the strobed bit as bit 0 of a new word
//   pout, pout_vld, pout_rdy   head of the output FIFO and its handshake
//   busy          partial word in progress
//   ovf           sticky overrun (word dropped on full FIFO)
//   perr          sticky parity error (0 when parity is not built in)
module shiftreg_deser #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sin,
   input  logic             sin_vld,
   input  logic             sync,
   output logic [WIDTH-1:0] pout,
   output logic             pout_vld,
   input  logic             pout_rdy,
   output logic             busy,
   output logic             ovf,
   output logic             perr
);

`ifdef SHIFTREG_DESER_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam int unsigned CNT_W = $clog2(FRAME + 1);

   typedef enum logic {IDLE, RECV} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   buf0_q, buf0_d;
   logic [WIDTH-1:0]   buf1_q, buf1_d;
   logic [1:0]         occ_q, occ_d;
   logic               pout_vld_q, pout_vld_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;
   logic               perr_q, perr_d;

   logic [WIDTH-1:0]   shift_nxt;
   logic [WIDTH-1:0]   word_c;
   logic               push_c;
   logic               perr_set_c;
   logic               take_c;
   logic               pop_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!en)
         state_d = IDLE;
      else if (state_q == IDLE && sin_vld && sync)
         state_d = RECV;
   end

   // Shift register with the incoming bit inserted on the side chosen by MSB_FIRST
   always_comb begin
      shift_nxt = MSB_FIRST ? {shift_q[WIDTH-2:0], sin} : {sin, shift_q[WIDTH-1:1]};
   end

   // Bit accumulation and word completion
   always_comb begin
      count_d    = count_q;
      shift_d    = shift_q;
      push_c     = 1'b0;
      perr_set_c = 1'b0;
      word_c     = shift_nxt;
      // In IDLE only a sync-marked bit is accepted
      take_c     = en && sin_vld && (state_q == RECV || sync);
      if (!en) begin
         count_d = '0;
      end else if (take_c) begin
         if (sync) begin
            // Start or resync: this bit is bit 0 regardless of partial progress
            shift_d = shift_nxt;
            count_d = CNT_W'(1);
         end else if (count_q == CNT_W'(FRAME - 1)) begin
`ifdef SHIFTREG_DESER_PARITY_EN
            // Parity slot: word already assembled, sin is the even-parity bit
            count_d = '0;
            word_c  = shift_q;
            if ((^shift_q) == sin) push_c = 1'b1;
            else                   perr_set_c = 1'b1;
`else
            shift_d = shift_nxt;
            count_d = '0;
            push_c  = 1'b1;
`endif
         end else begin
            shift_d = shift_nxt;
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // Output FIFO and flag updates; buf0 is always the head shown on pout
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      occ_d  = occ_q;
      ovf_d  = ovf_q;
      perr_d = perr_q | perr_set_c;
      pop_c  = pout_vld_q && pout_rdy;
      case ({push_c, pop_c})
         2'b10: begin
            case (occ_q)
               2'd0: begin
                  buf0_d = word_c;
                  occ_d  = 2'd1;
               end
               2'd1: begin
                  buf1_d = word_c;
                  occ_d  = 2'd2;
               end
               default: ovf_d = 1'b1;
            endcase
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged; head advances
            if (occ_q == 2'd2) begin
               buf0_d = buf1_q;
               buf1_d = word_c;
            end else begin
               buf0_d = word_c;
            end
         end
         default: ;
      endcase
      pout_vld_d = (occ_d != 2'd0);
      busy_d     = (count_d != '0);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         shift_q    <= '0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         occ_q      <= 2'd0;
         pout_vld_q <= 1'b0;
         busy_q     <= 1'b0;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
      end else begin
         count_q    <= count_d;
         shift_q    <= shift_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         occ_q      <= occ_d;
         pout_vld_q <= pout_vld_d;
         busy_q     <= busy_d;
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
      end
   end

   assign pout     = buf0_q;
   assign pout_vld = pout_vld_q;
   assign busy     = busy_q;
   assign ovf      = ovf_q;
   assign perr     = perr_q;

endmodule

// File: tb/tb_shiftreg_deser.sv
// Testbench for shiftreg_deser: drives one MSB_FIRST=1 and one MSB_FIRST=0 instance
// with the same serial stream; expected words are queued at stimulus time and a
// monitor pops/compares whenever a word is handed over (pout_vld && pout_rdy).
module tb_shiftreg_deser;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst, en, sin, sin_vld, sync, rdy;
   logic [W-1:0] pout_m, pout_l;
   logic         vld_m, vld_l, busy_m, busy_l, ovf_m, ovf_l, perr_m, perr_l;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] q_m[$];
   logic [W-1:0] q_l[$];

   always #5 clk = ~clk;

   shiftreg_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .en(en), .sin(sin), .sin_vld(sin_vld), .sync(sync),
      .pout(pout_m), .pout_vld(vld_m), .pout_rdy(rdy),
      .busy(busy_m), .ovf(ovf_m), .perr(perr_m));

   shiftreg_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .en(en), .sin(sin), .sin_vld(sin_vld), .sync(sync),
      .pout(pout_l), .pout_vld(vld_l), .pout_rdy(rdy),
      .busy(busy_l), .ovf(ovf_l), .perr(perr_l));

   function automatic logic [W-1:0] rev8(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s);
      sin     = b;
      sin_vld = 1'b1;
      sync    = s;
      tick();
      sin_vld = 1'b0;
      sync    = 1'b0;
      sin     = 1'b0;
   endtask

   // seq[7] is sent first; MSB-first receiver yields seq, LSB-first yields rev8(seq)
   task automatic send_word(input logic [W-1:0] seq, input bit first_sync, input bit expect_out,
                            input bit rdy_on_last, input bit bad_par);
      if (expect_out) begin
         q_m.push_back(seq);
         q_l.push_back(rev8(seq));
      end
      for (int i = W - 1; i >= 0; i--) begin
`ifndef SHIFTREG_DESER_PARITY_EN
         if (rdy_on_last && i == 0) rdy = 1'b1;
`endif
         send_bit(seq[i], first_sync && (i == W - 1));
      end
`ifdef SHIFTREG_DESER_PARITY_EN
      if (rdy_on_last) rdy = 1'b1;
      send_bit((^seq) ^ bad_par, 1'b0);
`endif
   endtask

   task automatic chk_both(input string name, input logic am, input logic al, input logic exp);
      chk({name, "_m"}, 32'(am), 32'(exp));
      chk({name, "_l"}, 32'(al), 32'(exp));
   endtask

   // Scoreboard monitor: a word is consumed at the next rising edge
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && vld_m && rdy) begin
            checks++;
            if (q_m.size() == 0) begin
               errors++;
               $display("FAIL mon_msb unexpected word actual=%h expected=none", pout_m);
            end else begin
               e = q_m.pop_front();
               if (pout_m !== e) begin
                  errors++;
                  $display("FAIL mon_msb word actual=%h expected=%h", pout_m, e);
               end
            end
         end
         if (!rst && vld_l && rdy) begin
            checks++;
            if (q_l.size() == 0) begin
               errors++;
               $display("FAIL mon_lsb unexpected word actual=%h expected=none", pout_l);
            end else begin
               e = q_l.pop_front();
               if (pout_l !== e) begin
                  errors++;
                  $display("FAIL mon_lsb word actual=%h expected=%h", pout_l, e);
               end
            end
         end
      end
   end

   initial begin
      logic [W-1:0] a5;
      rst = 1'b1; en = 1'b0; sin = 1'b0; sin_vld = 1'b0; sync = 1'b0; rdy = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_pout_m", 32'(pout_m), 32'h0);
      chk("rst_pout_l", 32'(pout_l), 32'h0);
      chk_both("rst_vld", vld_m, vld_l, 1'b0);
      chk_both("rst_busy", busy_m, busy_l, 1'b0);
      chk_both("rst_ovf", ovf_m, ovf_l, 1'b0);
      chk_both("rst_perr", perr_m, perr_l, 1'b0);
      en = 1'b1;

      // Single word A5 with latency and busy checks
      a5 = 8'hA5;
      q_m.push_back(8'hA5);
      q_l.push_back(8'hA5);
      for (int i = W - 1; i >= 0; i--) begin
         send_bit(a5[i], i == W - 1);
         if (i == 5) chk_both("s1_busy_mid", busy_m, busy_l, 1'b1);
         if (i == 1) chk_both("s1_vld_early", vld_m, vld_l, 1'b0);
      end
`ifdef SHIFTREG_DESER_PARITY_EN
      chk_both("s1_vld_before_par", vld_m, vld_l, 1'b0);
      send_bit(1'b0, 1'b0);
`endif
      chk_both("s1_vld", vld_m, vld_l, 1'b1);
      chk("s1_pout_m", 32'(pout_m), 32'hA5);
      chk("s1_pout_l", 32'(pout_l), 32'hA5);
      chk_both("s1_busy_end", busy_m, busy_l, 1'b0);
      rdy = 1'b1;
      tick(); tick();
      chk_both("s1_drained", vld_m, vld_l, 1'b0);

      // Back-to-back words into a stalled FIFO: third one overruns
      rdy = 1'b0;
      send_word(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      send_word(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_both("s2_ovf_pre", ovf_m, ovf_l, 1'b0);
      send_word(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_both("s2_ovf", ovf_m, ovf_l, 1'b1);
      chk("s2_head_m", 32'(pout_m), 32'h3C);
      rdy = 1'b1;
      tick(); tick(); tick();
      chk_both("s2_drained", vld_m, vld_l, 1'b0);

      // Partial word then resync: only 5A delivered
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      chk_both("s3_busy", busy_m, busy_l, 1'b1);
      send_word(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      tick(); tick();
      chk_both("s3_vld", vld_m, vld_l, 1'b0);
      chk_both("s3_busy_end", busy_m, busy_l, 1'b0);

      // Reset mid-word with a buffered word: everything discarded
      rdy = 1'b0;
      send_word(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      chk_both("s4_busy_pre", busy_m, busy_l, 1'b1);
      chk_both("s4_vld_pre", vld_m, vld_l, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_both("s4_vld", vld_m, vld_l, 1'b0);
      chk_both("s4_busy", busy_m, busy_l, 1'b0);
      chk_both("s4_ovf", ovf_m, ovf_l, 1'b0);
      send_bit(1'b1, 1'b0);
      chk_both("s4_nosync_ignored", busy_m, busy_l, 1'b0);

      // en low drops a partial word
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      en = 1'b0;
      tick();
      chk_both("s5_en_busy", busy_m, busy_l, 1'b0);
      en = 1'b1;
      send_bit(1'b1, 1'b0);
      chk_both("s5_en_idle", busy_m, busy_l, 1'b0);

      // 35 sent LSB first (sequence AC), fill FIFO, then push+pop while full
      send_word(8'hAC, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("s5_pout_l", 32'(pout_l), 32'h35);
      chk("s5_pout_m", 32'(pout_m), 32'hAC);
      send_word(8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
      send_word(8'h9F, 1'b0, 1'b1, 1'b1, 1'b0);
      chk_both("s5_ovf", ovf_m, ovf_l, 1'b0);
      chk_both("s5_vld_full", vld_m, vld_l, 1'b1);
      tick(); tick(); tick();
      chk_both("s5_drained", vld_m, vld_l, 1'b0);

`ifdef SHIFTREG_DESER_PARITY_EN
      // Parity: good word accepted, bad word dropped with perr
      rdy = 1'b0;
      send_word(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("p_pout_m", 32'(pout_m), 32'hA5);
      chk_both("p_perr_pre", perr_m, perr_l, 1'b0);
      send_word(8'hA4, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_both("p_perr", perr_m, perr_l, 1'b1);
      rdy = 1'b1;
      tick(); tick();
      chk_both("p_drained", vld_m, vld_l, 1'b0);
`else
      chk_both("perr_tied", perr_m, perr_l, 1'b0);
`endif

      chk("q_msb_empty", 32'(q_m.size()), 32'h0);
      chk("q_lsb_empty", 32'(q_l.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shiftreg_deser.md
Name: shiftreg_deser

Overview:
- Serial-to-parallel receiver for the codebase's universal shift register.
- Consumes the single-bit serial stream that the shift register emits on its serial output and reassembles it into WIDTH-bit words.
- Completed words go into a 2-entry output buffer, read through a valid/ready handshake.
- Sits at the far end of the serial link; the shift register is the transmitter.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1: first received bit lands in pout[WIDTH-1]; 0: first received bit lands in pout[0]

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  receiver enable; low forces IDLE and discards any partial word
sin  input  1  serial data bit
sin_vld  input  1  sin is sampled on this cycle
sync  input  1  word boundary; meaningful only with sin_vld; marks the current bit as bit 0 of a new word
pout  output  WIDTH  head word of the output buffer
pout_vld  output  1  pout holds a valid word
pout_rdy  input  1  consumer accepts pout when pout_vld && pout_rdy
busy  output  1  a partial word is being accumulated (bit count != 0)
ovf  output  1  sticky overrun flag
perr  output  1  sticky parity error flag (see Optional Feature)

Behaviour:
- Reset: state=IDLE, bit count=0, shift reg=0, buffer empty; pout=0, pout_vld=0, busy=0, ovf=0, perr=0. Reset mid-word discards the partial word and all buffered words.
- States:
  - IDLE: sin_vld without sync is ignored. en && sin_vld && sync -> RECV, with this bit captured as bit 0 (count=1).
  - RECV: each sin_vld captures one bit and increments the count.
  - en=0 in any state: next state is IDLE, count=0; buffered words are kept.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at the LSB. After WIDTH bits, the first bit is at the MSB.
  - MSB_FIRST=0: shift right, new bit enters at the MSB. After WIDTH bits, the first bit is at the LSB.
- Word completion: on the sin_vld that makes count==WIDTH, the assembled word (including that bit) is pushed to the buffer and count returns to 0. The state stays RECV, so the next bit starts the next word with no sync needed (back-to-back words).
- Latency: pout_vld rises on the cycle after the final bit's sin_vld cycle when the buffer was empty.
- Resync: sync with sin_vld while in RECV and count!=0 discards the partial bits and restarts at count=1 with this bit. sync with count==0 is a normal first bit.
- Buffer:
  - 2-entry FIFO, first-in first-out; pout shows the head entry and is registered.
  - Pop on pout_vld && pout_rdy.
  - Push while full with no pop in the same cycle: the new word is dropped, contents are unchanged, and ovf is set.
  - Simultaneous push and pop while full: accepted, no overrun.
  - Push and pop while holding 1 entry: occupancy stays 1, and pout advances to the new word.
- ovf and perr clear only on rst.
- busy = (count != 0), registered.
- pout is stable while pout_vld && !pout_rdy.

Optional Feature:
- Macro: SHIFTREG_DESER_PARITY_EN.
- Defined:
  - Each word is followed by one extra bit, giving even parity over WIDTH+1 bits.
  - The word is pushed on the sin_vld of that parity bit, so latency is measured from the parity bit.
  - On mismatch the word is dropped and perr is set (sticky).
  - sync on the parity-bit slot counts as a resync.
- Not defined: WIDTH-bit framing only, and perr is tied to 0.

Test Plan:
- Parity macro undefined for all scenarios except the last.
- MSB_FIRST=1, en=1: send bits 1,0,1,0,0,1,0,1, sync on the first -> pout=8'hA5, pout_vld=1 one cycle after the 8th strobe; busy=0.
- pout_rdy=0: send 8'h3C, 8'h81, 8'h7E back-to-back, sync only on the first -> ovf=1 after the third word. Then drain with pout_rdy=1 -> 8'h3C, then 8'h81, then pout_vld=0.
- Send 3 bits, then sync + 8'h5A -> only 8'h5A is output; busy=1 during the 3 bits.
- Reset mid-word (after 5 bits) with one word buffered -> next cycle pout_vld=0, busy=0, ovf=0. A subsequent bit without sync is ignored.
- MSB_FIRST=0: send bits of 8'h35 LSB first -> pout=8'h35. Full buffer plus simultaneous push/pop -> no ovf, order preserved.
- SHIFTREG_DESER_PARITY_EN defined:
  - 8'hA5 with parity bit 0 -> pout=8'hA5.
  - 8'hA4 with parity bit 0 -> no push, perr=1.
